// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with forwarding hold and optional perf counters.
// Define MEM_WB_PERF_CNT_EN to build retired_cnt/stall_cnt; otherwise they read as 0.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic        valid_in,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN_in,
    input  logic [3:0]  Dest_in,
    input  logic [31:0] ALU_res_in,
    input  logic [31:0] MEM_out_in,
    input  logic        perf_clr,
    output logic        WB_EN_out,
    output logic [3:0]  WB_Dest,
    output logic [31:0] WB_Value,
    output logic        fwd_valid,
    output logic [3:0]  fwd_dest,
    output logic [31:0] fwd_value,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
);
    logic        valid_q;
    logic        wb_en_q;
    logic        mem_r_q;
    logic [3:0]  dest_q;
    logic [31:0] alu_q;
    logic [31:0] mem_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            mem_r_q   <= 1'b0;
            dest_q    <= 4'd0;
            alu_q     <= 32'd0;
            mem_q     <= 32'd0;
            fwd_valid <= 1'b0;
            fwd_dest  <= 4'd0;
            fwd_value <= 32'd0;
        end else begin
            // A stall inserts a bubble so a held instruction is written back only once.
            if (ready) begin
                valid_q <= valid_in;
                wb_en_q <= valid_in & WB_EN_in;
                mem_r_q <= MEM_R_EN_in;
                dest_q  <= Dest_in;
                alu_q   <= ALU_res_in;
                mem_q   <= MEM_out_in;
            end else begin
                valid_q <= 1'b0;
                wb_en_q <= 1'b0;
            end
            fwd_valid <= WB_EN_out;
            fwd_dest  <= WB_Dest;
            fwd_value <= WB_Value;
        end
    end

    assign WB_EN_out = wb_en_q;
    assign WB_Dest   = dest_q;
    assign WB_Value  = mem_r_q ? mem_q : alu_q;

`ifdef MEM_WB_PERF_CNT_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            retired_q <= 32'd0;
            stall_q   <= 32'd0;
        end else if (perf_clr) begin
            retired_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            if (valid_q && retired_q != 32'hFFFF_FFFF) retired_q <= retired_q + 32'd1;
            if (!ready && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign retired_cnt = 32'd0;
    assign stall_cnt   = 32'd0;
`endif
endmodule
